cycle_ctrl: RTL

CYCLE_CTRL -- requirements
Module: cycle_ctrl

---
 rtl/cycle_ctrl_pkg.sv | 18 +
 rtl/cycle_ctrl_cnt.sv | 54 +++++
 rtl/cycle_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cycle_ctrl_pkg.sv
// Shared types and constants for the cycle controller.
// The state encoding and the stop-cause codes are kept here so that the
// controller and anything observing it agree on the same values.
package cycle_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_COUNT = 2'd1;
  localparam logic [1:0] CAUSE_HALT  = 2'd2;
  localparam logic [1:0] CAUSE_BREAK = 2'd3;

endpackage

// File: rtl/cycle_ctrl_cnt.sv
// Counter pair for the cycle controller: a loadable down-counter tracking the
// cycles left in a run (with a "one left" flag used to end the run), and a
// saturating up-counter of enabled processor cycles.
module cycle_ctrl_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  input  logic             inc,
  output logic             rem_one,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] count_r;

  // Remaining-cycle down-counter: loaded on start, stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r <= ZERO_C;
    end else if (load) begin
      rem_r <= load_val;
    end else if (dec && (rem_r != ZERO_C)) begin
      rem_r <= rem_r - ONE_C;
    end else begin
      rem_r <= rem_r;
    end
  end

  // Enabled-cycle up-counter: cleared on start, holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= ZERO_C;
    end else if (clr) begin
      count_r <= ZERO_C;
    end else if (inc && (count_r != MAX_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign rem_one = (rem_r == ONE_C);
  assign count   = count_r;

endmodule

// File: rtl/cycle_ctrl.sv
// Run/step controller gating the clock enable of a single-cycle processor.
// Optional feature macro: CYCLE_CTRL_BREAK_EN adds a PC breakpoint
// (pc, bp_addr, bp_valid) that ends a run or step with stop_cause=3.
module cycle_ctrl
  import cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CYCLE_CTRL_BREAK_EN
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
`endif
  input  logic             start,
  input  logic             step,
  input  logic             halt,
  input  logic [CNT_W-1:0] run_len,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       stop_cause
);

  state_t     state_r;
  state_t     next_s;
  logic [1:0] cause_r;
  logic [1:0] cause_nxt_s;
  logic       load_s;
  logic       clr_s;
  logic       inc_s;
  logic       dec_s;
  logic       rem_one_s;
  logic       brk_s;

`ifdef CYCLE_CTRL_BREAK_EN
  assign brk_s = bp_valid && (pc == bp_addr);
`else
  assign brk_s = 1'b0;
`endif

  cycle_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (run_len),
    .dec      (dec_s),
    .clr      (clr_s),
    .inc      (inc_s),
    .rem_one  (rem_one_s),
    .count    (cycles)
  );

  // State and stop-cause registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= next_s;
      cause_r <= cause_nxt_s;
    end
  end

  // Next state, stop cause and counter controls.
  always_comb begin
    next_s      = state_r;
    cause_nxt_s = cause_r;
    load_s      = 1'b0;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    dec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          clr_s  = 1'b1;
          if (run_len != {CNT_W{1'b0}}) begin
            cause_nxt_s = CAUSE_NONE;
            next_s      = ST_RUN;
          end else begin
            // Empty run: finish immediately without enabling the core.
            cause_nxt_s = CAUSE_COUNT;
            next_s      = ST_DONE;
          end
        end else if (step) begin
          next_s = ST_STEP;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        inc_s = 1'b1;
        dec_s = 1'b1;
        // Halt beats breakpoint beats count exhaustion.
        if (halt) begin
          cause_nxt_s = CAUSE_HALT;
          next_s      = ST_DONE;
        end else if (brk_s) begin
          cause_nxt_s = CAUSE_BREAK;
          next_s      = ST_DONE;
        end else if (rem_one_s) begin
          cause_nxt_s = CAUSE_COUNT;
          next_s      = ST_DONE;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_STEP: begin
        inc_s  = 1'b1;
        next_s = ST_IDLE;
        if (brk_s) begin
          cause_nxt_s = CAUSE_BREAK;
        end else begin
          cause_nxt_s = cause_r;
        end
      end
      ST_DONE: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign core_en    = busy;
  assign done       = (state_r == ST_DONE);
  assign stop_cause = cause_r;

endmodule
